reg_issue: RTL and testbench

REG_ISSUE -- requirements
Module: reg_issue

---
 rtl/reg_issue_pkg.sv | 36 +++
 rtl/reg_issue_rf.sv | 41 ++++
 rtl/reg_issue.sv | 143 ++++++++++++++
 tb/tb_reg_issue.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_issue_pkg.sv
// Shared encodings for the register-issue block: FSM states, instruction
// field positions and the opcode-class bit value.
package reg_issue_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned IMM_W   = 12;

  // instrWord[15] selects the instruction class
  localparam int unsigned CLASS_BIT   = 15;
  localparam logic        CLASS_LOADI = 1'b1;

  // ALU op fields
  localparam int unsigned OP_HI     = 14;
  localparam int unsigned OP_LO     = 13;
  localparam int unsigned ALU_RD_HI = 12;
  localparam int unsigned ALU_RD_LO = 10;
  localparam int unsigned RA_HI     = 9;
  localparam int unsigned RA_LO     = 7;
  localparam int unsigned RB_HI     = 6;
  localparam int unsigned RB_LO     = 4;

  // load-immediate fields
  localparam int unsigned LI_RD_HI = 14;
  localparam int unsigned LI_RD_LO = 12;
  localparam int unsigned IMM_HI   = 11;
  localparam int unsigned IMM_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_issue_rf.sv
// General register file: two combinational read ports, one debug read port,
// one synchronous write port. Register 0 is hard-wired to zero.
//   rdAddrA/rdA_c, rdAddrB/rdB_c : operand read ports
//   dbgAddr/dbgData_c            : test read port
//   wrEn/wrAddr/wrData           : write port (writes to address 0 dropped)
module reg_issue_rf
  import reg_issue_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [WIDTH-1:0]  rdA_c,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  rdB_c,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [WIDTH-1:0]  dbgData_c,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData
);

  logic [WIDTH-1:0] regs [NREGS];

  // storage; address 0 never written so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (wrEn && (wrAddr != '0)) begin
      regs[wrAddr] <= wrData;
    end
  end

  // read ports; zero forced for address 0 as well
  assign rdA_c     = (rdAddrA == '0) ? '0 : regs[rdAddrA];
  assign rdB_c     = (rdAddrB == '0) ? '0 : regs[rdAddrB];
  assign dbgData_c = (dbgAddr == '0) ? '0 : regs[dbgAddr];

endmodule

// File: rtl/reg_issue.sv
// Register-read / issue stage in front of an external combinational ALU.
// Accepts ALU ops (IDLE->EXEC->WB) and load-immediates (IDLE->WB), writes
// results back to the register file and pulses a write-back strobe.
//   instrValid/instrReady/instrWord : instruction handshake
//   rdDataA/rdDataB/opSelect        : registered ALU operands and op
//   outData                         : ALU result
//   wbValid/wbAddr/wbData           : registered write-back pulse
//   dbgAddr/dbgData                 : combinational register read for test
module reg_issue
  import reg_issue_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instrValid,
  output logic               instrReady,
  input  logic [INSTR_W-1:0] instrWord,
  output logic [WIDTH-1:0]   rdDataA,
  output logic [WIDTH-1:0]   rdDataB,
  output logic [OP_W-1:0]    opSelect,
  input  logic [WIDTH-1:0]   outData,
  output logic               wbValid,
  output logic [ADDR_W-1:0]  wbAddr,
  output logic [WIDTH-1:0]   wbData,
  input  logic [ADDR_W-1:0]  dbgAddr,
  output logic [WIDTH-1:0]   dbgData
);

  state_t            state;
  logic [ADDR_W-1:0] pendRd;

  logic              accept_c;
  logic              isLoadI_c;
  logic [OP_W-1:0]   opField;
  logic [ADDR_W-1:0] aluRd;
  logic [ADDR_W-1:0] raField;
  logic [ADDR_W-1:0] rbField;
  logic [ADDR_W-1:0] liRd;
  logic [WIDTH-1:0]  immExt;
  logic [WIDTH-1:0]  rfA;
  logic [WIDTH-1:0]  rfB;
  logic              rfWrEn;
  logic [ADDR_W-1:0] rfWrAddr;
  logic [WIDTH-1:0]  rfWrData;
  logic              unusedBits;

  // instruction decode
  assign accept_c  = instrValid && instrReady;
  assign isLoadI_c = (instrWord[CLASS_BIT] == CLASS_LOADI);
  assign opField   = instrWord[OP_HI:OP_LO];
  assign aluRd     = instrWord[ALU_RD_HI:ALU_RD_LO];
  assign raField   = instrWord[RA_HI:RA_LO];
  assign rbField   = instrWord[RB_HI:RB_LO];
  assign liRd      = instrWord[LI_RD_HI:LI_RD_LO];
  assign immExt    = WIDTH'(instrWord[IMM_HI:IMM_LO]);
  assign unusedBits = ^instrWord[RB_LO-1:0];

  // write port: ALU result in EXEC, immediate on a load-immediate accept
  always_comb begin
    rfWrEn   = 1'b0;
    rfWrAddr = pendRd;
    rfWrData = outData;
    if (state == ST_EXEC) begin
      rfWrEn = 1'b1;
    end else if ((state == ST_IDLE) && accept_c && isLoadI_c) begin
      rfWrEn   = 1'b1;
      rfWrAddr = liRd;
      rfWrData = immExt;
    end
  end

  reg_issue_rf #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdAddrA   (raField),
    .rdA_c     (rfA),
    .rdAddrB   (rbField),
    .rdB_c     (rfB),
    .dbgAddr   (dbgAddr),
    .dbgData_c (dbgData),
    .wrEn      (rfWrEn),
    .wrAddr    (rfWrAddr),
    .wrData    (rfWrData)
  );

  // control FSM with registered outputs; instrReady mirrors state==IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      instrReady <= 1'b1;
      rdDataA    <= '0;
      rdDataB    <= '0;
      opSelect   <= '0;
      pendRd     <= '0;
      wbValid    <= 1'b0;
      wbAddr     <= '0;
      wbData     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            instrReady <= 1'b0;
            if (isLoadI_c) begin
              wbValid <= 1'b1;
              wbAddr  <= liRd;
              wbData  <= immExt;
              state   <= ST_WB;
            end else begin
              // operands read before any write of this op lands
              rdDataA  <= rfA;
              rdDataB  <= rfB;
              opSelect <= opField;
              pendRd   <= aluRd;
              state    <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          wbValid <= 1'b1;
          wbAddr  <= pendRd;
          wbData  <= outData;
          state   <= ST_WB;
        end
        ST_WB: begin
          wbValid    <= 1'b0;
          instrReady <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          wbValid    <= 1'b0;
          instrReady <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_issue.sv
// Scenario bench for reg_issue with a behavioural stand-in for the team ALU
// (0 add, 1 sub, 2 xor, 3 and). Expected write-backs are queued when
// instructions are issued and compared as the DUT reports them.
module tb_reg_issue;

  localparam int unsigned WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instrValid;
  logic              instrReady;
  logic [15:0]       instrWord;
  logic [WIDTH-1:0]  rdDataA;
  logic [WIDTH-1:0]  rdDataB;
  logic [1:0]        opSelect;
  logic [WIDTH-1:0]  outData;
  logic              wbValid;
  logic [2:0]        wbAddr;
  logic [WIDTH-1:0]  wbData;
  logic [2:0]        dbgAddr;
  logic [WIDTH-1:0]  dbgData;

  always #5 clk = ~clk;

  reg_issue #(.WIDTH(WIDTH), .NREGS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .instrWord  (instrWord),
    .rdDataA    (rdDataA),
    .rdDataB    (rdDataB),
    .opSelect   (opSelect),
    .outData    (outData),
    .wbValid    (wbValid),
    .wbAddr     (wbAddr),
    .wbData     (wbData),
    .dbgAddr    (dbgAddr),
    .dbgData    (dbgData)
  );

  // team ALU stand-in
  always_comb begin
    case (opSelect)
      2'd0:    outData = rdDataA + rdDataB;
      2'd1:    outData = rdDataA - rdDataB;
      2'd2:    outData = rdDataA ^ rdDataB;
      default: outData = rdDataA & rdDataB;
    endcase
  end

  function automatic logic [15:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
    logic [15:0] r;
    if (op == 2'd0)      r = 16'(a + b);
    else if (op == 2'd1) r = 16'(a - b);
    else if (op == 2'd2) r = a ^ b;
    else                 r = a & b;
    return r;
  endfunction

  function automatic logic [15:0] encLi(input logic [2:0] rd, input logic [11:0] imm);
    return {1'b1, rd, imm};
  endfunction

  function automatic logic [15:0] encAlu(input logic [1:0] op, input logic [2:0] rd,
                                         input logic [2:0] ra, input logic [2:0] rb);
    return {1'b0, op, rd, ra, rb, 4'b1010};
  endfunction

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } got_t;

  exp_t        expQ[$];
  got_t        gotQ[$];
  logic [15:0] progQ[$];
  int          acceptCyc[$];
  logic        readyTrace[$];
  logic [15:0] aTrace[$];
  logic [15:0] bTrace[$];
  logic [1:0]  opTrace[$];

  int total = 0;
  int bad = 0;

  // Drives progQ with instrValid held high and records per-cycle observations.
  // Sample k is taken at the falling edge before rising edge k.
  task automatic runProg(input int nCyc);
    logic rdy;
    got_t g;
    gotQ.delete(); acceptCyc.delete(); readyTrace.delete();
    aTrace.delete(); bTrace.delete(); opTrace.delete();
    for (int k = 0; k < nCyc; k++) begin
      if (progQ.size() > 0) begin
        instrValid = 1'b1;
        instrWord  = progQ[0];
      end else begin
        instrValid = 1'b0;
        instrWord  = '0;
      end
      rdy = instrReady;
      readyTrace.push_back(rdy);
      aTrace.push_back(rdDataA);
      bTrace.push_back(rdDataB);
      opTrace.push_back(opSelect);
      if (wbValid) begin
        g.addr = wbAddr; g.data = wbData; g.cyc = k;
        gotQ.push_back(g);
      end
      @(posedge clk);
      if (instrValid && rdy) begin
        void'(progQ.pop_front());
        acceptCyc.push_back(k);
      end
      @(negedge clk);
    end
    instrValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instrValid = 1'b0; instrWord = '0; dbgAddr = '0;
    repeat (2) @(negedge clk);
    total++; if (instrReady !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", instrReady); end
    total++; if (wbValid !== 1'b0) begin bad++; $display("FAIL rst_wbValid got=%b want=0", wbValid); end
    total++; if ({wbAddr, wbData} !== '0) begin bad++; $display("FAIL rst_wb got=%h/%h want=0/0", wbAddr, wbData); end
    total++; if ({rdDataA, rdDataB, opSelect} !== '0) begin bad++;
      $display("FAIL rst_operands got=%h/%h/%h want=0", rdDataA, rdDataB, opSelect); end
    for (int r = 0; r < 8; r++) begin
      dbgAddr = 3'(r); #1;
      total++; if (dbgData !== 16'h0) begin bad++; $display("FAIL rst_reg%0d got=%h want=0", r, dbgData); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // REQ: two loads, one pulse each, two cycles apart
  task automatic test_load();
    exp_t e;
    progQ.push_back(encLi(3'd1, 12'd35)); expQ.push_back('{3'd1, 16'd35});
    progQ.push_back(encLi(3'd2, 12'd5));  expQ.push_back('{3'd2, 16'd5});
    runProg(8);
    total++; if (gotQ.size() != 2) begin bad++; $display("FAIL load_count got=%0d want=2", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      total++; if (gotQ[i].addr !== e.addr || gotQ[i].data !== e.data) begin bad++;
        $display("FAIL load_wb%0d got=%0d:%h want=%0d:%h", i, gotQ[i].addr, gotQ[i].data, e.addr, e.data); end
      if (i < acceptCyc.size()) begin
        total++; if (gotQ[i].cyc - acceptCyc[i] != 1) begin bad++;
          $display("FAIL load_latency%0d got=%0d want=1", i, gotQ[i].cyc - acceptCyc[i]); end
      end
    end
    if (gotQ.size() == 2) begin
      total++; if (gotQ[1].cyc - gotQ[0].cyc != 2) begin bad++;
        $display("FAIL load_spacing got=%0d want=2", gotQ[1].cyc - gotQ[0].cyc); end
    end
    expQ.delete();
  endtask

  // REQ: r3 = r1 op1 r2, operands visible during EXEC
  task automatic test_alu_op();
    exp_t e;
    int a;
    progQ.push_back(encAlu(2'd1, 3'd3, 3'd1, 3'd2));
    expQ.push_back('{3'd3, aluModel(16'd35, 16'd5, 2'd1)});
    runProg(5);
    total++; if (gotQ.size() != 1 || acceptCyc.size() != 1) begin bad++;
      $display("FAIL alu_count got=%0d/%0d want=1/1", gotQ.size(), acceptCyc.size()); end
    if (gotQ.size() > 0 && acceptCyc.size() > 0) begin
      a = acceptCyc[0];
      e = expQ.pop_front();
      total++; if (gotQ[0].addr !== e.addr || gotQ[0].data !== e.data) begin bad++;
        $display("FAIL alu_wb got=%0d:%h want=%0d:%h", gotQ[0].addr, gotQ[0].data, e.addr, e.data); end
      total++; if (gotQ[0].cyc - a != 2) begin bad++;
        $display("FAIL alu_latency got=%0d want=2", gotQ[0].cyc - a); end
      total++; if (aTrace[a+1] !== 16'd35 || bTrace[a+1] !== 16'd5 || opTrace[a+1] !== 2'd1) begin bad++;
        $display("FAIL alu_operands got=%0d/%0d/%0d want=35/5/1", aTrace[a+1], bTrace[a+1], opTrace[a+1]); end
    end
    dbgAddr = 3'd3; #1;
    total++; if (dbgData !== aluModel(16'd35, 16'd5, 2'd1)) begin bad++;
      $display("FAIL alu_reg3 got=%h want=%h", dbgData, aluModel(16'd35, 16'd5, 2'd1)); end
    @(negedge clk);
    expQ.delete();
  endtask

  // REQ: all four ops back to back with instrValid held high
  task automatic test_back_to_back();
    exp_t e;
    int a;
    progQ.push_back(encLi(3'd1, 12'd30)); expQ.push_back('{3'd1, 16'd30});
    progQ.push_back(encLi(3'd2, 12'd12)); expQ.push_back('{3'd2, 16'd12});
    for (int op = 0; op < 4; op++) begin
      progQ.push_back(encAlu(2'(op), 3'(4 + op), 3'd1, 3'd2));
      expQ.push_back('{3'(4 + op), aluModel(16'd30, 16'd12, 2'(op))});
    end
    runProg(20);
    total++; if (gotQ.size() != 6 || acceptCyc.size() != 6) begin bad++;
      $display("FAIL b2b_count got=%0d/%0d want=6/6", gotQ.size(), acceptCyc.size()); end
    for (int i = 0; i < gotQ.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      total++; if (gotQ[i].addr !== e.addr || gotQ[i].data !== e.data) begin bad++;
        $display("FAIL b2b_wb%0d got=%0d:%h want=%0d:%h", i, gotQ[i].addr, gotQ[i].data, e.addr, e.data); end
    end
    for (int i = 2; i < acceptCyc.size(); i++) begin
      a = acceptCyc[i];
      total++; if (readyTrace[a+1] !== 1'b0 || readyTrace[a+2] !== 1'b0) begin bad++;
        $display("FAIL b2b_ready%0d got=%b%b want=00", i, readyTrace[a+1], readyTrace[a+2]); end
      if (i > 2) begin
        total++; if (a - acceptCyc[i-1] != 3) begin bad++;
          $display("FAIL b2b_spacing%0d got=%0d want=3", i, a - acceptCyc[i-1]); end
      end
    end
    for (int op = 0; op < 4; op++) begin
      dbgAddr = 3'(4 + op); #1;
      total++; if (dbgData !== aluModel(16'd30, 16'd12, 2'(op))) begin bad++;
        $display("FAIL b2b_reg%0d got=%h want=%h", 4 + op, dbgData, aluModel(16'd30, 16'd12, 2'(op))); end
    end
    @(negedge clk);
    expQ.delete();
  endtask

  // REQ: register 0 discards writes but the pulse still happens
  task automatic test_zero_reg();
    exp_t e;
    int a;
    progQ.push_back(encLi(3'd0, 12'hABC));         expQ.push_back('{3'd0, 16'h0ABC});
    progQ.push_back(encAlu(2'd0, 3'd6, 3'd0, 3'd0)); expQ.push_back('{3'd6, 16'h0000});
    runProg(7);
    total++; if (gotQ.size() != 2 || acceptCyc.size() != 2) begin bad++;
      $display("FAIL zero_count got=%0d/%0d want=2/2", gotQ.size(), acceptCyc.size()); end
    for (int i = 0; i < gotQ.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      total++; if (gotQ[i].addr !== e.addr || gotQ[i].data !== e.data) begin bad++;
        $display("FAIL zero_wb%0d got=%0d:%h want=%0d:%h", i, gotQ[i].addr, gotQ[i].data, e.addr, e.data); end
    end
    if (acceptCyc.size() == 2) begin
      a = acceptCyc[1];
      total++; if (aTrace[a+1] !== 16'h0 || bTrace[a+1] !== 16'h0) begin bad++;
        $display("FAIL zero_operands got=%h/%h want=0/0", aTrace[a+1], bTrace[a+1]); end
    end
    dbgAddr = 3'd0; #1;
    total++; if (dbgData !== 16'h0) begin bad++; $display("FAIL zero_reg0 got=%h want=0", dbgData); end
    @(negedge clk);
    expQ.delete();
  endtask

  // REQ: rd == ra == rb reads the pre-write value
  task automatic test_same_reg();
    exp_t e;
    int a;
    progQ.push_back(encLi(3'd1, 12'd7));             expQ.push_back('{3'd1, 16'd7});
    progQ.push_back(encAlu(2'd0, 3'd1, 3'd1, 3'd1)); expQ.push_back('{3'd1, aluModel(16'd7, 16'd7, 2'd0)});
    runProg(7);
    total++; if (gotQ.size() != 2 || acceptCyc.size() != 2) begin bad++;
      $display("FAIL same_count got=%0d/%0d want=2/2", gotQ.size(), acceptCyc.size()); end
    for (int i = 0; i < gotQ.size() && expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      total++; if (gotQ[i].addr !== e.addr || gotQ[i].data !== e.data) begin bad++;
        $display("FAIL same_wb%0d got=%0d:%h want=%0d:%h", i, gotQ[i].addr, gotQ[i].data, e.addr, e.data); end
    end
    if (acceptCyc.size() == 2) begin
      a = acceptCyc[1];
      total++; if (aTrace[a+1] !== 16'd7 || bTrace[a+1] !== 16'd7) begin bad++;
        $display("FAIL same_operands got=%0d/%0d want=7/7", aTrace[a+1], bTrace[a+1]); end
    end
    dbgAddr = 3'd1; #1;
    total++; if (dbgData !== aluModel(16'd7, 16'd7, 2'd0)) begin bad++;
      $display("FAIL same_reg1 got=%h want=%h", dbgData, aluModel(16'd7, 16'd7, 2'd0)); end
    @(negedge clk);
    expQ.delete();
  endtask

  // REQ: reset during EXEC abandons the op; next instruction accepted at once
  task automatic test_reset_exec();
    exp_t e;
    logic rdy;
    progQ.push_back(encLi(3'd1, 12'd9));
    progQ.push_back(encLi(3'd2, 12'd4));
    runProg(5);
    instrValid = 1'b1;
    instrWord  = encAlu(2'd0, 3'd5, 3'd1, 3'd2);
    rdy = instrReady;
    @(posedge clk);
    @(negedge clk);
    instrValid = 1'b0;
    total++; if (rdy !== 1'b1 || rdDataA !== 16'd9 || rdDataB !== 16'd4) begin bad++;
      $display("FAIL rexec_issue got=%b/%0d/%0d want=1/9/4", rdy, rdDataA, rdDataB); end
    rst_n = 1'b0;
    dbgAddr = 3'd5;
    #1;
    total++; if ({wbValid, wbAddr, wbData, rdDataA, rdDataB, opSelect} !== '0) begin bad++;
      $display("FAIL rexec_outputs got=%b/%h/%h/%h/%h/%h want=0", wbValid, wbAddr, wbData, rdDataA, rdDataB, opSelect); end
    total++; if (instrReady !== 1'b1) begin bad++; $display("FAIL rexec_ready got=%b want=1", instrReady); end
    total++; if (dbgData !== 16'h0) begin bad++; $display("FAIL rexec_reg5 got=%h want=0", dbgData); end
    @(negedge clk);
    rst_n = 1'b1;
    progQ.push_back(encLi(3'd5, 12'h123)); expQ.push_back('{3'd5, 16'h0123});
    runProg(4);
    total++; if (gotQ.size() != 1 || acceptCyc.size() != 1) begin bad++;
      $display("FAIL rexec_count got=%0d/%0d want=1/1", gotQ.size(), acceptCyc.size()); end
    if (acceptCyc.size() > 0) begin
      total++; if (acceptCyc[0] != 0) begin bad++; $display("FAIL rexec_accept got=%0d want=0", acceptCyc[0]); end
    end
    if (gotQ.size() > 0 && expQ.size() > 0) begin
      e = expQ.pop_front();
      total++; if (gotQ[0].addr !== e.addr || gotQ[0].data !== e.data) begin bad++;
        $display("FAIL rexec_wb got=%0d:%h want=%0d:%h", gotQ[0].addr, gotQ[0].data, e.addr, e.data); end
    end
    dbgAddr = 3'd5; #1;
    total++; if (dbgData !== 16'h0123) begin bad++; $display("FAIL rexec_reg5_after got=%h want=0123", dbgData); end
    @(negedge clk);
    expQ.delete();
  endtask

  initial begin
    instrValid = 1'b0;
    instrWord  = '0;
    dbgAddr    = '0;
    test_reset();
    test_load();
    test_alu_op();
    test_back_to_back();
    test_zero_reg();
    test_same_reg();
    test_reset_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
